// File: rtl/mma_tile_sequencer_if.sv
// Bundle of the start/operand/result handshakes around one MMA tile sequencer.
// dbg_state mirrors the sequencer FSM state for observation only.
interface mma_tile_sequencer_if #(
    parameter int M = 4,
    parameter int N = 4,
    parameter int K = 4,
    parameter int P = 8
);
    localparam int AW = 4 * P;

    logic                            start;
    logic [7:0]                      k_tiles;
    logic [M-1:0][N-1:0][AW-1:0]     c_in;
    logic                            busy;
    logic                            in_valid;
    logic                            in_ready;
    logic [M-1:0][K-1:0][P-1:0]      in_a;
    logic [K-1:0][N-1:0][P-1:0]      in_b;
    logic [7:0]                      k_idx;
    logic                            out_valid;
    logic                            out_ready;
    logic [M-1:0][N-1:0][AW-1:0]     out_d;
    logic [1:0]                      dbg_state;

    // valid/ready: a transfer happens on a rising edge where both are high;
    // valid never depends combinationally on ready, and the payload holds while
    // valid is high and ready is low.
    modport master (
        output start, k_tiles, c_in, in_valid, in_a, in_b, out_ready,
        input  busy, in_ready, k_idx, out_valid, out_d, dbg_state
    );

    modport slave (
        input  start, k_tiles, c_in, in_valid, in_a, in_b, out_ready,
        output busy, in_ready, k_idx, out_valid, out_d, dbg_state
    );
endinterface

// File: rtl/mma_tile_sequencer.sv
// Accumulates D = C + sum(A_t * B_t) over a run of K-direction tile pairs,
// one pair per cycle, and holds D on a valid/ready output until taken.
module mma_tile_sequencer #(
    parameter int M = 4,
    parameter int N = 4,
    parameter int K = 4,
    parameter int P = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    mma_tile_sequencer_if.slave  bus
);
    localparam int AW = 4 * P;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCUM  = 2'd1,
        S_OUTPUT = 2'd2
    } state_e;

    state_e                       state_q, state_d;
    logic [M-1:0][N-1:0][AW-1:0]  acc_q, acc_d;
    logic [M-1:0][N-1:0][AW-1:0]  dp_d;
    logic [7:0]                   k_idx_q, k_idx_d;
    logic [7:0]                   k_tiles_q, k_tiles_d;
    logic                         in_ready_q, in_ready_d;
    logic                         out_valid_q, out_valid_d;
    logic                         busy_q, busy_d;

    // Combinational datapath: unsigned products, sums wrap modulo 2^AW.
    always_comb begin
        dp_d = acc_q;
        for (int i = 0; i < M; i++) begin
            for (int j = 0; j < N; j++) begin
                for (int k = 0; k < K; k++) begin
                    dp_d[i][j] = dp_d[i][j] + AW'(bus.in_a[i][k]) * AW'(bus.in_b[k][j]);
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        k_idx_d   = k_idx_q;
        k_tiles_d = k_tiles_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    acc_d     = bus.c_in;
                    k_tiles_d = bus.k_tiles;
                    k_idx_d   = 8'd0;
                    state_d   = (bus.k_tiles == 8'd0) ? S_OUTPUT : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (bus.in_valid && in_ready_q) begin
                    acc_d   = dp_d;
                    k_idx_d = k_idx_q + 8'd1;
                    if (k_idx_q + 8'd1 == k_tiles_q) begin
                        state_d = S_OUTPUT;
                    end
                end
            end
            S_OUTPUT: begin
                if (out_valid_q && bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Flags come from the next state so they are pure flop outputs.
        in_ready_d  = (state_d == S_ACCUM);
        out_valid_d = (state_d == S_OUTPUT);
        busy_d      = (state_d == S_ACCUM) || (state_d == S_OUTPUT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            acc_q       <= '0;
            k_idx_q     <= 8'd0;
            k_tiles_q   <= 8'd0;
            in_ready_q  <= 1'b0;
            out_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            k_idx_q     <= k_idx_d;
            k_tiles_q   <= k_tiles_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.busy      = busy_q;
    assign bus.k_idx     = k_idx_q;
    assign bus.out_d     = acc_q;
    assign bus.dbg_state = state_q;
endmodule

// File: doc/mma_tile_sequencer.md
# mma_tile_sequencer

Sequential controller that drives one instance of the team's combinational `matrix_multiplication_accumulation` datapath to compute D = C + Σ A_t·B_t over a run of K-direction operand tiles. The block:
- loads the initial accumulator C on `start`;
- consumes `k_tiles` (A,B) tile pairs from an upstream valid/ready stream, one per cycle, feeding the registered accumulator back as the datapath's C input;
- presents the final D tile on a valid/ready output.

It sits between the operand fetch logic and the result writeback.

## Interface
- M, 4: rows of A/C/D tile
- N, 4: columns of B/C/D tile
- K, 4: inner dimension of one tile pair
- P, 8: operand element width; accumulator element width is 4*P
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  begin a run; sampled only in IDLE
- k_tiles  in  8  number of tile pairs in the run, latched on accepted start
- c_in  in  [4*P-1:0] x M x N  initial accumulator, latched on accepted start
- busy  out  1  high in ACCUM and OUTPUT
- in_valid  in  1  upstream tile pair valid
- in_ready  out  1  high only in ACCUM
- in_a  in  [P-1:0] x M x K  A tile
- in_b  in  [P-1:0] x K x N  B tile
- k_idx  out  8  number of tile pairs accepted in the current run
- out_valid  out  1  D tile valid
- out_ready  in  1  downstream accepts D
- out_d  out  [4*P-1:0] x M x N  result tile, equal to the accumulator register

## Operation
- States: IDLE, ACCUM, OUTPUT.
- IDLE:
  - start=1 latches c_in into acc, latches k_tiles and clears k_idx.
  - If k_tiles≠0, next state is ACCUM; if k_tiles=0, next state is OUTPUT (D=C).
  - start=0 keeps the block in IDLE.
- ACCUM:
  - in_ready=1. On in_valid&&in_ready: acc ← datapath(A=in_a, B=in_b, C=acc) and k_idx ← k_idx+1.
  - When the accepted pair is number k_tiles, next state is OUTPUT. Without in_valid, state and acc hold.
- OUTPUT:
  - out_valid=1, and out_d is held stable.
  - On out_valid&&out_ready, next state is IDLE. acc and k_idx keep their values until the next start.
- start is ignored outside IDLE. It is not queued.
- Arithmetic:
  - Products are P×P, zero-extended to 4*P.
  - Sums wrap modulo 2^(4*P). There is no saturation and no overflow flag.
  - Operands are unsigned.
- rst=1 in any state, including mid-ACCUM or mid-OUTPUT, gives the following on the next edge:
  - state IDLE;
  - acc=0, k_idx=0, latched k_tiles=0;
  - any partial run is discarded.
  - rst has priority over start and over all handshakes.

## Timing
- Reset values: busy=0, in_ready=0, out_valid=0, k_idx=0, out_d all zero.
- in_ready, out_valid and busy are decoded from registered state only. There is no combinational path from in_valid or out_ready to in_ready or out_valid.
- Start accepted at edge 0:
  - busy=1 and in_ready=1 from cycle 1 (k_tiles>0).
  - out_valid=1 in cycle 1 (k_tiles=0).
- Tile acceptance:
  - A tile accepted at edge t updates acc and k_idx at edge t+1.
  - Throughput is one tile pair per cycle.
- Latency with in_valid continuously high: the last tile is accepted in cycle k_tiles, and out_valid rises in cycle k_tiles+1.
- in_ready drops in the cycle after the last accepted tile, so no extra tile is consumed.
- Output handshake in cycle t: state is IDLE and busy=0 at t+1. A start asserted during OUTPUT is ignored. The earliest new start is accepted in cycle t+1.
- Datapath is combinational inside one cycle. The clock-period constraint is a K-deep add chain plus multiply.

## Test plan
- M=N=K=2, P=8, k_tiles=1, C=0, A=[[1,2],[3,4]], B=identity, in_valid held high. Required: out_valid in cycle 2 and D=[[1,2],[3,4]]. in_ready must be high only in cycle 1.
- k_tiles=3, A and B all ones, C all 5, in_valid high. Required:
  - every D element = 11;
  - k_idx steps 1, 2, 3;
  - out_valid rises in cycle 4.
- k_tiles=0, C all 7. Required:
  - out_valid in cycle 1 with D all 7;
  - in_ready never asserted;
  - a start pulse during OUTPUT is ignored.
- Backpressure with k_tiles=4:
  - in_valid toggles 1,0,1,0,... Required: exactly 4 pairs accepted and D correct.
  - out_ready is then held low 5 cycles. Required: out_valid and out_d stable throughout; IDLE on the cycle after out_ready=1.
- Wrap-around: C all 0xFFFFFFFF, A and B all ones, k_tiles=1. Required: every D element = 0x00000001.
- Reset mid-run: rst=1 for one cycle after 2 of 4 tiles accepted. Required:
  - next cycle busy=0, in_ready=0, k_idx=0, out_d all zero;
  - a following run with k_tiles=1, C=0, A=[[1,2],[3,4]], B=identity yields D=[[1,2],[3,4]] with no residue from the aborted run.
